// File: rtl/load_store_unit.sv
// Load/store unit between the multi-cycle control FSM and a word-addressed memory port.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault instead of aligning down.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        fault,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_next;
    logic          write_q;
    logic [31:0]   addr_q;
    logic [2:0]    funct3_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          fault_q;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;

    logic          illegal;
    logic          timed_out;
    logic [31:0]   wdata_lane;
    logic [3:0]    be_next;

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (f3[1:0])
            2'b00:   extract = {{24{b[7] & ~f3[2]}}, b};
            2'b01:   extract = {{16{h[15] & ~f3[2]}}, h};
            default: extract = d;
        endcase
    endfunction

    always_comb begin
        illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                  || (req_write && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
            (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
            illegal = 1'b1;
`endif
    end

    // Stores replicate the datum into every lane; byte enables select the live one.
    always_comb begin
        wdata_lane = req_wdata;
        be_next    = 4'b1111;
        if (req_write) begin
            case (req_funct3[1:0])
                2'b00: begin
                    wdata_lane = {4{req_wdata[7:0]}};
                    be_next    = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                    wdata_lane = {2{req_wdata[15:0]}};
                    be_next    = 4'b0011 << {req_addr[1], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = illegal ? RESP : ACCESS;
            ACCESS:  if (mem_ack || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            fault_q  <= 1'b0;
            cnt      <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (req_valid) begin
                    write_q  <= req_write;
                    addr_q   <= req_addr;
                    funct3_q <= req_funct3;
                    wdata_q  <= wdata_lane;
                    be_q     <= be_next;
                    fault_q  <= illegal;
                    cnt      <= '0;
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    // Ack takes priority over a coincident timeout.
                    if (mem_ack) begin
                        fault_q <= 1'b0;
                        if (!write_q) rdata_q <= extract(funct3_q, addr_q[1:0], mem_rdata);
                    end else if (timed_out) begin
                        fault_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign fault     = rsp_valid & fault_q;
    assign rsp_rdata = rdata_q;
    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en & write_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

endmodule
